// File: rtl/commit_report_sched.sv
// commit_report_sched
// Gathers per-hart instruction-commit records into per-hart FIFOs and
// serializes them round-robin onto a single registered report channel.
//
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   in_valid/in_ready    per-hart push handshake (bit h = hart h)
//   in_pc/in_inst        per-hart 32-bit fields, hart h at [32h+31:32h]
//   in_is_mmio           per-hart MMIO flag
//   in_rcsr_id           per-hart 12-bit CSR id, hart h at [12h+11:12h]
//   out_valid/out_ready  report channel handshake
//   out_pc/out_inst/out_is_mmio/out_rcsr_id/out_hartid  registered record
//   protocol_err         sticky: a record was offered to a full FIFO

module commit_report_sched #(
   parameter int unsigned NUM_HARTS = 2,
   parameter int unsigned DEPTH     = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [NUM_HARTS-1:0]    in_valid,
   output logic [NUM_HARTS-1:0]    in_ready,
   input  logic [32*NUM_HARTS-1:0] in_pc,
   input  logic [32*NUM_HARTS-1:0] in_inst,
   input  logic [NUM_HARTS-1:0]    in_is_mmio,
   input  logic [12*NUM_HARTS-1:0] in_rcsr_id,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_pc,
   output logic [31:0]             out_inst,
   output logic                    out_is_mmio,
   output logic [11:0]             out_rcsr_id,
   output logic [31:0]             out_hartid,
   output logic                    protocol_err
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        is_mmio;
      logic [11:0] rcsr_id;
   } rec_t;

   rec_t                 fifo_head [NUM_HARTS];
   logic [NUM_HARTS-1:0] push;
   logic [NUM_HARTS-1:0] pop;
   logic [NUM_HARTS-1:0] nonempty;

   logic [HW-1:0]        rr_ptr;
   logic [HW-1:0]        rr_next;
   logic [HW-1:0]        grant_idx;
   logic                 grant_found;
   logic                 load;
   rec_t                 head;
   int unsigned          scan;

   // Output register may take a new record when empty or being consumed
   assign load = !out_valid || out_ready;

   // Per-hart FIFO: count-based occupancy, pointers wrap naturally (DEPTH is a power of two)
   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_hart
      rec_t          mem [DEPTH];
      rec_t          wr_rec;
      logic [AW-1:0] wr_ptr;
      logic [AW-1:0] rd_ptr;
      logic [CW-1:0] count;

      assign wr_rec       = {in_pc[32*h +: 32], in_inst[32*h +: 32],
                             in_is_mmio[h], in_rcsr_id[12*h +: 12]};
      // Ready comes only from registered occupancy; a same-cycle pop does not free a slot
      assign in_ready[h]  = (count < CW'(DEPTH));
      assign nonempty[h]  = (count != '0);
      assign push[h]      = in_valid[h] && in_ready[h];
      assign pop[h]       = load && grant_found && (grant_idx == HW'(h));
      assign fifo_head[h] = mem[rd_ptr];

      // Pointer and occupancy tracking
      always_ff @(posedge clock or posedge reset) begin
         if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
         end else begin
            if (push[h]) begin
               wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop[h]) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
            if (push[h] && !pop[h]) begin
               count <= count + CW'(1);
            end else if (!push[h] && pop[h]) begin
               count <= count - CW'(1);
            end
         end
      end

      // Storage array, no reset needed: occupancy gates every read
      always_ff @(posedge clock) begin
         if (push[h]) begin
            mem[wr_ptr] <= wr_rec;
         end
      end
   end

   // Round-robin scan: first non-empty hart at or after rr_ptr, with wrap
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan        = 0;
      for (int unsigned i = 0; i < NUM_HARTS; i++) begin
         scan = (32'(rr_ptr) + i) % NUM_HARTS;
         if (!grant_found && nonempty[HW'(scan)]) begin
            grant_found = 1'b1;
            grant_idx   = HW'(scan);
         end
      end
   end

   assign rr_next = HW'((32'(grant_idx) + 32'd1) % NUM_HARTS);
   assign head    = fifo_head[grant_idx];

   // Registered report channel, round-robin pointer and sticky overflow flag
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         out_valid    <= 1'b0;
         out_pc       <= '0;
         out_inst     <= '0;
         out_is_mmio  <= 1'b0;
         out_rcsr_id  <= '0;
         out_hartid   <= '0;
         rr_ptr       <= '0;
         protocol_err <= 1'b0;
      end else begin
         if (|(in_valid & ~in_ready)) begin
            protocol_err <= 1'b1;
         end
         if (load) begin
            out_valid <= grant_found;
            // With nothing queued the data fields keep their last value
            if (grant_found) begin
               out_pc      <= head.pc;
               out_inst    <= head.inst;
               out_is_mmio <= head.is_mmio;
               out_rcsr_id <= head.rcsr_id;
               out_hartid  <= 32'(grant_idx);
               rr_ptr      <= rr_next;
            end
         end
      end
   end

endmodule

// File: doc/commit_report_sched.md
Name: commit_report_sched

Overview:
- Collects per-hart instruction-commit records (pc, inst, MMIO flag, read-CSR id) from NUM_HARTS cores.
- Buffers each hart's records in its own FIFO.
- Serializes them round-robin onto one registered reporting channel, at most one record per clock, with a hart id attached.
- Sits between the cores' commit stages and the single commit-report/difftest sink.
- Absorbs bursts; applies per-hart backpressure when the sink stalls.

Parameters:
- NUM_HARTS, 2, number of requesting harts (1..8).
- DEPTH, 4, entries per hart FIFO (power of two, ≥2).

Ports:
- clock  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  NUM_HARTS  bit h: hart h offers a commit record.
- in_ready  output  NUM_HARTS  bit h: hart h FIFO can accept a record.
- in_pc  input  32*NUM_HARTS  hart h pc in bits [32h+31:32h].
- in_inst  input  32*NUM_HARTS  hart h instruction word.
- in_is_mmio  input  NUM_HARTS  hart h commit touched MMIO.
- in_rcsr_id  input  12*NUM_HARTS  hart h CSR address read (0 if none).
- out_valid  output  1  record present on out_*.
- out_ready  input  1  sink consumes the record this cycle.
- out_pc  output  32  record pc.
- out_inst  output  32  record instruction.
- out_is_mmio  output  1  record MMIO flag.
- out_rcsr_id  output  12  record CSR id.
- out_hartid  output  32  source hart index, zero-extended.
- protocol_err  output  1  sticky: a record was offered while in_ready was low.

Behaviour:
- Reset (async, immediate):
  - All FIFOs empty; rr_ptr=0.
  - out_valid=0; out_pc/out_inst/out_rcsr_id/out_hartid/out_is_mmio=0.
  - protocol_err=0.
  - in_ready = all ones during and after reset.
  - Reset mid-operation discards all buffered and presented records.
- Push: record accepted for hart h when in_valid[h] && in_ready[h] at a rising edge; written to FIFO h tail.
- in_ready[h]: derived solely from the registered occupancy, = (count_h < DEPTH). A full FIFO popped in the same cycle still shows in_ready=0; there is no pass-through.
- Output register load condition: load = !out_valid || out_ready.
  - On load with at least one non-empty FIFO: grant the first non-empty hart scanning from rr_ptr upward with wrap. Pop its head into out_* and set out_valid=1.
  - Then rr_ptr = (granted+1) mod NUM_HARTS.
  - On load with all FIFOs empty: out_valid=0; out data holds its last value; rr_ptr unchanged.
- Stall: while out_valid && !out_ready, all out_* hold stable and no FIFO pops. Pushes continue until full.
- Latency: record pushed at edge E appears on out_* after edge E+1 (2 edges minimum, no bypass).
- Throughput: one record per cycle while out_ready=1 and data is queued.
- Ordering: per-hart order preserved. Cross-hart order is round-robin only.
- Simultaneous push and pop on the same FIFO: both take effect; count unchanged.
- Pointer wrap: FIFO pointers are log2(DEPTH) bits plus a wrap bit, or an equivalent count.
- Overflow: in_valid[h] && !in_ready[h] at an edge drops the record and sets protocol_err=1. It is cleared only by reset.
- NUM_HARTS=1: rr_ptr is constant 0; out_hartid is always 0.

Test Plan:
- Single record: hart0 pushes pc=0x80000000, inst=0x00000013, rcsr_id=0, out_ready=1 -> out_valid=1 exactly two edges after the push, with out_pc=0x80000000, out_inst=0x00000013, out_hartid=0. out_valid=0 the next cycle.
- Concurrent traffic: both harts push every cycle for 4 cycles with pcs 0x100..0x10C (hart0) and 0x200..0x20C (hart1), out_ready=1 -> out_hartid sequence 0,1,0,1,... and 8 records total, each hart's pcs ascending.
- Backpressure: out_ready=0, hart0 pushes continuously -> 5 records accepted (1 in the output register, 4 in the FIFO), then in_ready[0]=0. out_pc holds the first pc stable. Raising out_ready drains the 5 in order, one per cycle.
- Overflow: with hart1 FIFO full, drive in_valid[1]=1 with pc=0xDEAD0000 -> protocol_err=1 and stays 1. 0xDEAD0000 is never emitted; hart0 is unaffected.
- Fairness: hart1 has 3 queued and hart0 pushes 1 while the last grant was hart1 -> hart0 granted next, then hart1 resumes.
- Async reset mid-stream: assert reset between edges with records queued and out_valid=1 -> out_valid=0 and protocol_err=0 immediately. After release, in_ready is all ones and no stale record ever appears.
